// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath select.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t cur_state;
  state_t next_state;
  logic [2:0] alu_decoded;

  always_ff @(posedge clk) begin
    if (!reset) cur_state <= FETCH;
    else        cur_state <= next_state;
  end

  // Memory-facing states hold until mem_ready; TRAP only leaves via reset.
  always_comb begin
    next_state = cur_state;
    unique case (cur_state)
      FETCH:    if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: if (mem_ready) next_state = FETCH;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
      JAL:      next_state = ALUWB;
      TRAP:     next_state = TRAP;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  alu_decoded = (funct7b5 && op[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_decoded = ALU_SLT;
      3'b110:  alu_decoded = ALU_OR;
      3'b111:  alu_decoded = ALU_AND;
      default: alu_decoded = ALU_ADD;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BEQ:      ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    case (cur_state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decoded;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decoded;
      end
      ALUWB: RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = zero;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      TRAP:    illegal = 1'b1;
      default: ;
    endcase
  end

  assign state = STATE_W'(cur_state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded into
// its expected state sequence and control words, with random memory stalls.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int totalChecks = 0;
  int badChecks = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  wire [16:0] ctrlWord = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                          ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input logic rdy);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
    #1;
  endtask

  function automatic logic [1:0] immFor(input logic [6:0] o);
    if (o == LW || o == IT) return 2'b00;
    if (o == SW) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] aluFor(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (f7 && o == RT) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [16:0] expectedCtrl(input int ph, input logic [6:0] o, input logic [2:0] f3,
                                               input logic f7, input logic z, input logic rdy);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0;
    logic [2:0] alu = 3'b000;
    case (ph)
      0:  begin sb = 2; rs = 2; irw = rdy; pcw = rdy; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; alu = aluFor(o, f3, f7); end
      7:  begin sa = 2; sb = 1; alu = aluFor(o, f3, f7); end
      8:  rw = 1;
      9:  begin sa = 2; alu = 3'b001; pcw = z; end
      10: begin sa = 1; sb = 2; pcw = 1; end
      11: ill = 1;
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, immFor(o), ill};
  endfunction

  // Runs one instruction; abortAt >= 0 pulses reset in that cycle of the instruction.
  task automatic runInstr(input logic [6:0] o, input int abortAt);
    int phases[$];
    int base, idx, cycles, waits;
    logic [2:0] f3;
    logic f7, z, rdy;
    case (o)
      LW:      begin phases = '{0, 1, 2, 3, 4}; base = 5; end
      SW:      begin phases = '{0, 1, 2, 5};    base = 4; end
      RT:      begin phases = '{0, 1, 6, 8};    base = 4; end
      IT:      begin phases = '{0, 1, 7, 8};    base = 4; end
      BR:      begin phases = '{0, 1, 9};       base = 3; end
      JL:      begin phases = '{0, 1, 10, 8};   base = 4; end
      default: begin phases = '{0, 1, 11};      base = 3; end
    endcase
    idx = 0; cycles = 0; waits = 0;
    while (idx < phases.size()) begin
      f3 = 3'($urandom); f7 = 1'($urandom); z = 1'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(o, f3, f7, z, rdy);
      checkOutput("state", 32'(state), 32'(phases[idx]));
      checkOutput($sformatf("ctrl_s%0d", phases[idx]), 32'(ctrlWord),
                  32'(expectedCtrl(phases[idx], o, f3, f7, z, rdy)));
      if (cycles == abortAt || phases[idx] == 11) begin
        if (phases[idx] == 11) begin
          for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            applyStimulus(o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            checkOutput("trap_state", 32'(state), 32'd11);
            checkOutput("trap_illegal", 32'(illegal), 32'd1);
            checkOutput("trap_strobes", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
          end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checkOutput("reset_to_fetch", 32'(state), 32'd0);
        return;
      end
      @(posedge clk); #1;
      cycles++;
      if ((phases[idx] == 0 || phases[idx] == 3 || phases[idx] == 5) && !rdy) waits++;
      else idx++;
      if (cycles > 200) begin
        checkOutput("timeout", 32'(cycles), 32'd200);
        return;
      end
    end
    checkOutput("cycles", 32'(cycles), 32'(base + waits));
    checkOutput("back_to_fetch", 32'(state), 32'd0);
  endtask

  initial begin
    logic [6:0] o;
    int kind, base, abortAt;
    reset = 1'b0;
    applyStimulus(LW, 3'b000, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_irwrite", 32'(IRWrite), 32'd1);
    checkOutput("reset_pcwrite", 32'(PCWrite), 32'd1);
    checkOutput("reset_illegal", 32'(illegal), 32'd0);

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 20);
      case (kind)
        0, 1, 2:    begin o = LW; base = 5; end
        3, 4, 5:    begin o = SW; base = 4; end
        6, 7, 8, 9: begin o = RT; base = 4; end
        10, 11, 12: begin o = IT; base = 4; end
        13, 14, 15: begin o = BR; base = 3; end
        16, 17, 18: begin o = JL; base = 4; end
        default: begin
          o = 7'($urandom);
          while (o == LW || o == SW || o == RT || o == IT || o == BR || o == JL)
            o = 7'($urandom);
          base = 3;
        end
      endcase
      abortAt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, base - 1) : -1;
      runInstr(o, abortAt);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle variant of the RV32I core.
- Instruction and data fetches share one memory port, so the ALU and memory are reused across cycles.
- Each instruction is sequenced through FETCH/DECODE/EXECUTE/MEM/WB states, and the block drives every datapath mux select and write enable.
- Memory accesses stall on a ready handshake. An unsupported opcode parks the FSM in a trap state.

Parameters:
- STATE_W, 4, width of the state register and of the state debug output.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- op  in  7  instruction[6:0], taken from the instruction register.
- funct3  in  3  instruction[14:12].
- funct7b5  in  1  instruction[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current read or write this cycle.
- PCWrite  out  1  load the PC register.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load the instruction register and OldPC.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- illegal  out  1  high while in TRAP.
- state  out  STATE_W  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Reset: on a rising clk edge with reset=0, state <= FETCH. This applies from any state, including mid-instruction and TRAP; no partial writes are completed.
- Outputs are combinational from state, op, funct3, funct7b5, zero and mem_ready.
- Default for every output is 0, except ALUControl, which defaults to add.
- Every 1-bit strobe not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0; ALUSrcA=00; ALUSrcB=10; add; ResultSrc=10.
    - IRWrite = PCWrite = mem_ready.
    - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (computes the branch target).
    - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
    - op=0000011 -> MEMREAD; otherwise -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
    - Hold until mem_ready=1, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
    - MemWrite stays high until the cycle in which mem_ready=1, then -> FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALU decode -> ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALU decode -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
    - PCWrite = zero.
    - Next state is FETCH whether or not the branch is taken.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (rd <= PC+4).
  - TRAP: all strobes 0, illegal=1. Remains in TRAP until reset.
- ALU decode (EXECUTER/EXECUTEI), by funct3:
  - 000: sub when funct7b5=1 and op[5]=1; otherwise add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other value: add.
- ImmSrc is decoded from op in every state:
  - lw or I-type: 00.
  - sw: 01.
  - beq: 10.
  - jal: 11.
  - Otherwise: 00.
- Cycle counts with mem_ready tied to 1:
  - lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> state=0, IRWrite=1 and PCWrite=1 with mem_ready=1, illegal=0.
- lw: op=0000011, mem_ready=1 -> states 0,1,2,3,4,0.
  - RegWrite=1 only in state 4, with ResultSrc=01.
- sw with wait: op=0100011, mem_ready low for 2 cycles in MEMWRITE -> MemWrite high for 3 consecutive cycles, then state=0.
- R-type sub: op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER.
  - Same with funct7b5=0 -> 000.
  - funct3=111 -> 010.
- beq: zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0. Both cases return to FETCH in 3 cycles total.
- jal then illegal:
  - op=1101111 -> states 0,1,10,8,0, with ImmSrc=11 and PCWrite=1 in JAL.
  - Next fetch with op=1111111 -> TRAP, illegal=1 held for 10 cycles.
  - reset=0 for one edge -> state=0.
